// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmit serializer.
package i2s_pkg;

  localparam int CH_WIDTH   = 16;
  localparam int FRAME_BITS = 2 * CH_WIDTH;
  localparam int K_WIDTH    = $clog2(FRAME_BITS);

  // Channel slices within a stereo sample word: left in the upper half.
  localparam int LEFT_MSB  = FRAME_BITS - 1;
  localparam int LEFT_LSB  = CH_WIDTH;
  localparam int RIGHT_MSB = CH_WIDTH - 1;
  localparam int RIGHT_LSB = 0;

  typedef logic [K_WIDTH-1:0]    bit_idx_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  localparam bit_idx_t K_LAST = bit_idx_t'(FRAME_BITS - 1);

  // lrclk is high one BCLK ahead of the right-channel MSB and drops one BCLK
  // ahead of the next left-channel MSB (the I2S one-bit delay).
  localparam bit_idx_t LR_HIGH_FIRST = bit_idx_t'(CH_WIDTH - 1);
  localparam bit_idx_t LR_HIGH_LAST  = bit_idx_t'(FRAME_BITS - 2);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  function automatic chan_e chan_for_bit(input bit_idx_t k);
    return ((k >= LR_HIGH_FIRST) && (k <= LR_HIGH_LAST)) ? CH_RIGHT : CH_LEFT;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer_clk_div.sv
// BCLK generator: divides the system clock and flags each BCLK edge as a
// single-CLK tick that fires in the cycle before bclk actually toggles.
module i2s_clk_div #(
  parameter int DIV_HALF = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  output logic bclk,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CNT_W = (DIV_HALF > 2) ? $clog2(DIV_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_HALF - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             terminal;

  // Next-state for the half-period counter; disabling parks bclk low.
  always_comb begin
    terminal  = (div_cnt_q == CNT_LAST);
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    if (!en) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (terminal) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // Counter and bit-clock registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk      = bclk_q;
  assign fall_tick = en && terminal && bclk_q;
  assign rise_tick = en && terminal && !bclk_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: one-entry sample buffer with valid/ready, frame
// register and bit index, all outputs updated on BCLK falling events.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int DIV_HALF = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  en,
  input  logic [FRAME_BITS-1:0] sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  underrun
);

  logic     fall_tick;
  logic     rise_tick_unused;

  frame_t   hold_q, hold_d;
  logic     hold_full_q, hold_full_d;
  frame_t   frame_q, frame_d;
  bit_idx_t k_q, k_d;
  chan_e    lrclk_q, lrclk_d;
  logic     sdata_q, sdata_d;
  logic     underrun_q, underrun_d;

  logic     accept;
  bit_idx_t k_next;
  frame_t   load_word;

  // The codec samples on BCLK rises; this side only acts on falls.
  i2s_clk_div #(
    .DIV_HALF (DIV_HALF)
  ) u_clk_div (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .en        (en),
    .bclk      (bclk),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick_unused)
  );

  // Buffer handshake plus per-fall frame sequencing; an empty buffer at the
  // frame boundary sends a zero frame and flags underrun for one CLK.
  always_comb begin
    accept      = sample_valid && !hold_full_q;
    k_next      = k_q + 1'b1;
    load_word   = hold_full_q ? {hold_q[LEFT_MSB:LEFT_LSB], hold_q[RIGHT_MSB:RIGHT_LSB]} : '0;

    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_d     = frame_q;
    k_d         = k_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;

    if (accept) begin
      hold_d      = sample_data;
      hold_full_d = 1'b1;
    end

    if (!en) begin
      frame_d = '0;
      k_d     = K_LAST;
      lrclk_d = CH_LEFT;
      sdata_d = 1'b0;
    end else if (fall_tick) begin
      k_d     = k_next;
      lrclk_d = chan_for_bit(k_next);
      if (k_next == '0) begin
        frame_d    = load_word;
        sdata_d    = load_word[FRAME_BITS-1];
        underrun_d = !hold_full_q;
        if (hold_full_q) begin
          hold_full_d = 1'b0;
        end
      end else begin
        sdata_d = frame_q[K_LAST - k_next];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= '0;
      k_q         <= K_LAST;
      lrclk_q     <= CH_LEFT;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      k_q         <= k_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sample_ready = !hold_full_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun     = underrun_q;

endmodule
